// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// State encoding, digit width, all-off select pattern, counter sizing helper.
package seg_scan_pkg;

  typedef enum logic {
    ST_SHOW = 1'b0,
    ST_GAP  = 1'b1
  } state_t;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 32;

  // Active-low selects: all ones turns every digit off.
  localparam logic [MAX_DIGITS-1:0] DIGITS_OFF = '1;

  // Dwell counter width; never below one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Load bus and display outputs of the scan driver.
// master: load source / display consumer; slave: the scan driver.
interface seg_scan_driver_if
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 8
);

  logic                          load;
  logic [DIGIT_W*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]         dp_in;
  logic [NUM_DIGITS-1:0]         en_in;

  logic [DIGIT_W-1:0]            scan_nibble;
  logic                          scan_dp;
  logic                          blank;
  logic [NUM_DIGITS-1:0]         digit_sel;
  logic                          frame_start;

  modport master (
    output load, data_in, dp_in, en_in,
    input  scan_nibble, scan_dp, blank,
    input  digit_sel, frame_start
  );

  modport slave (
    input  load, data_in, dp_in, en_in,
    output scan_nibble, scan_dp, blank,
    output digit_sel, frame_start
  );

endinterface

// File: rtl/scan_dwell_counter.sv
// Dwell counter: counts up from zero, flags the terminal count.
// Ports: clk, rst, clr (load zero), sel_show (terminal select), cnt, done.
module scan_dwell_counter #(
  parameter int SHOW_CYCLES = 100000,
  parameter int GAP_CYCLES  = 1000,
  parameter int CW          = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          sel_show,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  logic [CW-1:0] last;

  assign last = sel_show ? SHOW_LAST : GAP_LAST;
  assign done = (cnt == last);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with double-buffered loads.
// Ports: clk, rst, bus (slave: load/data_in/dp_in/en_in in, scan outputs out).
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SHOW_CYCLES = 100000,
  parameter int GAP_CYCLES  = 1000
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_driver_if.slave   bus
);

  localparam int DW = DIGIT_W * NUM_DIGITS;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = cnt_width(SHOW_CYCLES, GAP_CYCLES);

  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF =
    DIGITS_OFF[NUM_DIGITS-1:0];
  localparam logic [NUM_DIGITS-1:0] SEL_ONE =
    NUM_DIGITS'(1);

  state_t                state;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         cnt;
  logic                  done;
  logic                  wrap;
  logic                  lit;

  logic [DW-1:0]         pend_data;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] pend_en;
  logic [DW-1:0]         act_data;
  logic [NUM_DIGITS-1:0] act_dp;
  logic [NUM_DIGITS-1:0] act_en;

  // Counter restarts on every state change, limit follows state.
  scan_dwell_counter #(
    .SHOW_CYCLES (SHOW_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .CW          (CW)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .clr      (done),
    .sel_show (state == ST_SHOW),
    .cnt      (cnt),
    .done     (done)
  );

  // Frame boundary: last GAP of the last digit.
  assign wrap = (state == ST_GAP) && done && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_GAP;
      idx       <= IDX_LAST;
      pend_data <= '0;
      pend_dp   <= '0;
      pend_en   <= '1;
      act_data  <= '0;
      act_dp    <= '0;
      act_en    <= '1;
    end else begin
      if (bus.load) begin
        pend_data <= bus.data_in;
        pend_dp   <= bus.dp_in;
        pend_en   <= bus.en_in;
      end
      if (done) begin
        unique case (state)
          ST_SHOW: begin
            state <= ST_GAP;
          end
          ST_GAP: begin
            state <= ST_SHOW;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end
          default: begin
            state <= ST_GAP;
          end
        endcase
      end
      // A load on the boundary edge bypasses straight to active.
      if (wrap) begin
        if (bus.load) begin
          act_data <= bus.data_in;
          act_dp   <= bus.dp_in;
          act_en   <= bus.en_in;
        end else begin
          act_data <= pend_data;
          act_dp   <= pend_dp;
          act_en   <= pend_en;
        end
      end
    end
  end

  assign lit = (state == ST_SHOW) && act_en[idx];

  assign bus.scan_nibble = act_data[idx*DIGIT_W +: DIGIT_W];
  assign bus.scan_dp     = act_dp[idx];
  assign bus.blank       = !lit;
  assign bus.digit_sel   = lit ? ~(SEL_ONE << idx) : SEL_OFF;
  assign bus.frame_start = (state == ST_SHOW) &&
                           (idx == '0) && (cnt == '0);

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (4 digits, show 3, gap 1).
// Expected per-cycle outputs are queued with stimulus, popped each cycle.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int SC = 3;
  localparam int GC = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seg_scan_driver_if #(.NUM_DIGITS(ND)) bus();

  seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .SHOW_CYCLES (SC),
    .GAP_CYCLES  (GC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] nib;
    logic       dp;
    logic       blank;
    logic       fs;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic push_rst();
    rec_t r;
    r.sel   = 4'hF;
    r.nib   = 4'h0;
    r.dp    = 1'b0;
    r.blank = 1'b1;
    r.fs    = 1'b0;
    q.push_back(r);
  endtask

  // Expected outputs for the first ncyc cycles of a frame.
  task automatic push_frame(input logic [15:0] d, input logic [3:0] p,
                            input logic [3:0] e, input int ncyc);
    rec_t r;
    int   n;
    logic show;
    n = 0;
    for (int k = 0; k < ND; k++) begin
      for (int c = 0; c < SC + GC; c++) begin
        if (n < ncyc) begin
          show    = (c < SC);
          r.nib   = d[4*k +: 4];
          r.dp    = p[k];
          r.blank = !(show && e[k]);
          r.sel   = (show && e[k]) ? ~(4'b0001 << k) : 4'hF;
          r.fs    = show && (k == 0) && (c == 0);
          q.push_back(r);
        end
        n++;
      end
    end
  endtask

  task automatic tick();
    rec_t r;
    @(negedge clk);
    cyc++;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL queue_empty cycle %0d: observed=0 expected>0", cyc);
    end else begin
      r = q.pop_front();
      chk("digit_sel",   bus.digit_sel,          r.sel);
      chk("scan_nibble", bus.scan_nibble,        r.nib);
      chk("scan_dp",     {3'b000, bus.scan_dp},     {3'b000, r.dp});
      chk("blank",       {3'b000, bus.blank},       {3'b000, r.blank});
      chk("frame_start", {3'b000, bus.frame_start}, {3'b000, r.fs});
    end
    bus.load = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_load(input logic [15:0] d, input logic [3:0] p,
                            input logic [3:0] e);
    bus.load    = 1'b1;
    bus.data_in = d;
    bus.dp_in   = p;
    bus.en_in   = e;
  endtask

  initial begin
    bus.load    = 1'b0;
    bus.data_in = '0;
    bus.dp_in   = '0;
    bus.en_in   = 4'hF;

    // Reset held two cycles.
    push_rst();
    push_rst();
    run(2);

    // Release; load coincides with the first boundary.
    rst = 1'b0;
    drive_load(16'h4321, 4'b0100, 4'hF);
    push_frame(16'h4321, 4'b0100, 4'hF, 16);
    push_frame(16'hABCD, 4'b0000, 4'hF, 16);

    // Mid-frame load while digit 1 is lit.
    run(5);
    drive_load(16'hABCD, 4'b0000, 4'hF);
    run(11);

    // Frame 2 shows D,C,B,A; load in its last GAP cycle.
    run(16);
    drive_load(16'h00F0, 4'b0001, 4'hF);
    push_frame(16'h00F0, 4'b0001, 4'hF, 16);

    // Frame 3: two loads, the last wins, with digits 0/2 disabled.
    run(3);
    drive_load(16'h5555, 4'hF, 4'hF);
    run(5);
    drive_load(16'h9876, 4'b0000, 4'b1010);
    run(8);
    push_frame(16'h9876, 4'b0000, 4'b1010, 16);
    run(16);

    // Frame 5: pending load, then reset during digit 2 SHOW.
    push_frame(16'h9876, 4'b0000, 4'b1010, 9);
    run(1);
    drive_load(16'hEEEE, 4'hF, 4'hF);
    run(8);
    rst = 1'b1;
    push_rst();
    tick();
    rst = 1'b0;
    push_frame(16'h0000, 4'b0000, 4'hF, 16);
    run(16);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed scan driver for the board's common 7-segment display bank.
- Holds a NUM_DIGITS-digit hex value and selects one digit at a time, with a blanked dead-time between digits to suppress ghosting.
- Feeds the 4-bit nibble to the hex-to-segment decoder (segmsg) directly downstream, and drives the active-low digit-select lines.
- Loads are double-buffered and applied only at frame boundaries, so a displayed frame never tears.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; must be >= 2.
- SHOW_CYCLES, 100000, clk cycles each digit is lit; must be >= 1.
- GAP_CYCLES, 1000, clk cycles all digits are off between digits; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high; one clock, no other clock domains.
- load  in  1  single-cycle strobe that captures data_in, dp_in and en_in into the pending buffer.
- data_in  in  4*NUM_DIGITS  hex value; digit i is data_in[4i+3:4i]; digit 0 is the rightmost digit.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- en_in  in  NUM_DIGITS  per-digit enable, 1 = digit displayed.
- scan_nibble  out  4  nibble of the current digit, sent to the decoder.
- scan_dp  out  1  decimal point of the current digit.
- blank  out  1  1 = downstream must force all segments off.
- digit_sel  out  NUM_DIGITS  one-hot active-low digit select; all ones = all digits off.
- frame_start  out  1  one-cycle pulse in the first SHOW cycle of digit 0.

Behaviour:
- Registers:
  - pending buffer (data, dp, en);
  - active (shadow) buffer (data, dp, en);
  - state in {SHOW, GAP};
  - idx in 0..NUM_DIGITS-1;
  - dwell counter cnt.
- Outputs are Moore, decoded combinationally from registers only; there is no combinational path from any input to any output.
- Reset values:
  - state = GAP, idx = NUM_DIGITS-1, cnt = 0;
  - pending and active data = 0, dp = 0, en = all ones.
- Outputs during and after reset: digit_sel = all ones, blank = 1, scan_nibble = 0, scan_dp = 0, frame_start = 0.
- SHOW state:
  - cnt counts 0..SHOW_CYCLES-1.
  - When cnt = SHOW_CYCLES-1: state becomes GAP, cnt becomes 0, idx is unchanged.
- GAP state:
  - cnt counts 0..GAP_CYCLES-1.
  - When cnt = GAP_CYCLES-1: state becomes SHOW, cnt becomes 0, idx becomes (idx+1) mod NUM_DIGITS.
  - idx wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the clock edge at which GAP moves to SHOW with idx wrapping to 0.
  - At this edge the active buffer takes the pending buffer.
  - If load=1 at that same edge, the active buffer takes data_in/dp_in/en_in directly (bypass), and pending also takes them.
- Load rules:
  - A load at any other edge updates pending only.
  - Multiple loads within one frame: the last one wins.
- Output decode (active buffer):
  - scan_nibble = active_data[4*idx +: 4] in both states.
  - scan_dp = active_dp[idx].
  - blank = (state==GAP) | ~active_en[idx].
  - digit_sel = all ones except bit idx = 0, only when state==SHOW and active_en[idx]=1.
  - frame_start = (state==SHOW) & (idx==0) & (cnt==0).
- Disabled digits: a digit with en=0 keeps its full SHOW slot with digit_sel all ones. Timing never changes, so brightness stays constant.
- Timing after rst release: GAP for GAP_CYCLES, then digit 0 SHOW. Frame period = NUM_DIGITS*(SHOW_CYCLES+GAP_CYCLES).
- Reset mid-operation: any state returns to the reset values at the next edge. Pending loads are discarded.
- Counter width is $clog2(max(SHOW_CYCLES, GAP_CYCLES)); compare using equality only.

Decomposition:
- Shared package seg_scan_pkg holds:
  - state encoding (ST_SHOW, ST_GAP);
  - DIGIT_W = 4;
  - localparam DIGITS_OFF (all-ones select).
- One sub-module, scan_dwell_counter:
  - inputs: load-zero and terminal-count select;
  - outputs: cnt and the done flag;
  - instantiated once, with the limit muxed by state.
- segmsg is not instantiated inside; the board top wires scan_nibble to it and gates its output with blank.

Test Plan (NUM_DIGITS=4, SHOW_CYCLES=3, GAP_CYCLES=1):
- Reset: hold rst 2 cycles -> digit_sel=4'hF, blank=1, scan_nibble=0, frame_start=0. After release, 1 blank cycle, then frame_start=1 and digit_sel=4'b1110.
- Scan order: load data 16'h4321 with en=4'hF, dp=4'b0100 before the first boundary.
  - scan_nibble shows 1,2,3,4, each for 3 cycles, separated by 1 blank cycle.
  - digit_sel steps 1110, 1101, 1011, 0111.
  - scan_dp=1 only in digit 2's slot; frame_start pulses every 16 cycles.
- Mid-frame load: load 16'hABCD while digit 1 is lit -> digits 1..3 still show 2,3,4. The next frame shows D,C,B,A.
- Coincident load: load 16'h00F0 in the last GAP cycle before the boundary -> the frame starting at the next edge shows 0,F,0,0.
- Disable: en=4'b1010 -> during the digit 0 and digit 2 slots, digit_sel=4'hF and blank=1. Digit 1 and digit 3 slots are unaffected; frame period stays 16.
- Reset mid-SHOW of digit 2 -> next cycle shows the reset outputs, active data=0, and the prior pending load is lost.
